// File: rtl/rpn_token_feeder.sv
// ASCII RPN text to calculator command converter: decimal numbers become pushes,
// operator characters become opcodes, one apply strobe per command.
module rpn_token_feeder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   char_in,
  input  logic         char_valid,
  output logic         char_ready,
  output logic [W-1:0] in,
  output logic [3:0]   op,
  output logic         apply,
  output logic         err
);

  typedef enum logic {IDLE, PEND_OP} state_t;

  state_t         state;
  logic [W-1:0]   acc;
  logic           have_num;
  logic [3:0]     pend_code;

  logic           is_digit;
  logic           is_delim;
  logic           is_op;
  logic [3:0]     code;
  logic [W+3:0]   acc_wide;
  logic           overflow;

  always_comb begin
    is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    is_delim = (char_in == 8'h20) || (char_in == 8'h0A) || (char_in == 8'h0D);
    is_op    = 1'b1;
    code     = 4'd0;
    case (char_in)
      8'h2B:   code = 4'd4;  // '+'
      8'h2D:   code = 4'd5;  // '-'
      8'h2A:   code = 4'd6;  // '*'
      8'h2F:   code = 4'd7;  // '/'
      8'h25:   code = 4'd8;  // '%'
      8'h69:   code = 4'd2;  // 'i'
      8'h64:   code = 4'd3;  // 'd'
      8'h70:   code = 4'd1;  // 'p'
      default: is_op = 1'b0;
    endcase
    // Four extra bits hold acc*10+9 for any W-bit acc without wrapping.
    acc_wide = {4'b0000, acc} * (W+4)'(10) + {{W{1'b0}}, char_in[3:0]};
    overflow = (acc_wide[W+3:W] != 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      char_ready <= 1'b1;
      in         <= '0;
      op         <= 4'd0;
      apply      <= 1'b0;
      err        <= 1'b0;
      acc        <= '0;
      have_num   <= 1'b0;
      pend_code  <= 4'd0;
    end else begin
      apply <= 1'b0;
      case (state)
        IDLE: begin
          if (char_valid && char_ready) begin
            if (is_digit) begin
              acc      <= acc_wide[W-1:0];
              have_num <= 1'b1;
              if (overflow) err <= 1'b1;
            end else if (is_delim) begin
              if (have_num) begin
                in       <= acc;
                op       <= 4'd0;
                apply    <= 1'b1;
                acc      <= '0;
                have_num <= 1'b0;
              end
            end else if (is_op) begin
              if (have_num) begin
                // Flush the pending number first; the operator follows next cycle.
                in         <= acc;
                op         <= 4'd0;
                apply      <= 1'b1;
                acc        <= '0;
                have_num   <= 1'b0;
                pend_code  <= code;
                state      <= PEND_OP;
                char_ready <= 1'b0;
              end else begin
                op    <= code;
                apply <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        PEND_OP: begin
          op         <= pend_code;
          apply      <= 1'b1;
          state      <= IDLE;
          char_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          char_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_token_feeder.sv
// Randomised and directed checks of rpn_token_feeder against a text-level model
// that predicts every command, its cycle and the sticky error flag.
module tb_rpn_token_feeder;
  localparam int W = 8;

  typedef struct {
    int cyc;
    int op;
    int val;
  } cmd_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   char_in = 8'h00;
  logic         char_valid = 1'b0;
  logic         char_ready;
  logic [W-1:0] in;
  logic [3:0]   op;
  logic         apply;
  logic         err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cmd_t exp_q[$];
  cmd_t obs_q[$];
  byte  stim[$];

  int m_acc;
  bit m_have;
  bit m_err;
  int m_last;

  rpn_token_feeder #(.W(W)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .in(in), .op(op), .apply(apply), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cmd_t c;
    if (apply === 1'b1) begin
      c.cyc = cyc;
      c.op  = int'(op);
      c.val = int'(in);
      obs_q.push_back(c);
    end
  end

  task automatic model_reset();
    m_acc = 0; m_have = 0; m_err = 0; m_last = 0;
    exp_q.delete();
    obs_q.delete();
    stim.delete();
  endtask

  task automatic expect_cmd(input int c, input int o, input int v);
    cmd_t e;
    e.cyc = c; e.op = o; e.val = v;
    exp_q.push_back(e);
  endtask

  // Character accepted on the edge following negedge count c0; its command shows at c0+1.
  task automatic model_accept(input byte ch, input int c0);
    int code;
    code = -1;
    case (ch)
      "+": code = 4;
      "-": code = 5;
      "*": code = 6;
      "/": code = 7;
      "%": code = 8;
      "i": code = 2;
      "d": code = 3;
      "p": code = 1;
      default: code = -1;
    endcase
    if (ch >= "0" && ch <= "9") begin
      m_acc  = m_acc * 10 + (int'(ch) - 48);
      m_have = 1;
      if (m_acc > (1 << W) - 1) begin
        m_err = 1;
        m_acc = m_acc % (1 << W);
      end
    end else if (ch == " " || ch == 8'h0A || ch == 8'h0D) begin
      if (m_have) begin
        expect_cmd(c0 + 1, 0, m_acc);
        m_last = m_acc; m_acc = 0; m_have = 0;
      end
    end else if (code >= 0) begin
      if (m_have) begin
        expect_cmd(c0 + 1, 0, m_acc);
        expect_cmd(c0 + 2, code, m_acc);
        m_last = m_acc; m_acc = 0; m_have = 0;
      end else begin
        expect_cmd(c0 + 1, code, m_last);
      end
    end else begin
      m_err = 1;
    end
  endtask

  // Called at a negedge; returns at the negedge after the character was taken.
  task automatic send_char(input byte ch, input bit gaps);
    int guard;
    while (gaps && $urandom_range(0, 3) == 0) begin
      char_valid = 1'b0;
      @(negedge clk);
    end
    char_valid = 1'b1;
    char_in    = ch;
    guard = 0;
    while (char_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 10) begin
      errors++;
      $display("FAIL ready_timeout char 0x%02h: char_ready got %b want 1", ch, char_ready);
    end
    model_accept(ch, cyc);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks += 5;
    if (in !== '0)        begin errors++; $display("FAIL reset_in: got %0d want 0", in); end
    if (op !== 4'd0)      begin errors++; $display("FAIL reset_op: got %0d want 0", op); end
    if (apply !== 1'b0)   begin errors++; $display("FAIL reset_apply: got %b want 0", apply); end
    if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    if (char_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", char_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    send_char("x", 0);
    send_char("4", 0);
    send_char("+", 0);
    // Push of 4 is on the outputs now and the '+' is pending.
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (in !== '0)        begin errors++; $display("FAIL midrst_in: got %0d want 0", in); end
    if (op !== 4'd0)      begin errors++; $display("FAIL midrst_op: got %0d want 0", op); end
    if (apply !== 1'b0)   begin errors++; $display("FAIL midrst_apply: got %b want 0", apply); end
    if (err !== 1'b0)     begin errors++; $display("FAIL midrst_err: got %b want 0", err); end
    if (char_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", char_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 0)
      begin errors++; $display("FAIL midrst_no_apply: got %0d pulses want 0", obs_q.size()); end
  endtask

  // Drives the loaded stimulus, then compares every command and the final flags.
  task automatic test_stream(input string name, input bit gaps);
    int n;
    for (int i = 0; i < stim.size(); i++) send_char(stim[i], gaps);
    repeat (6) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d cmds want %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks += 3;
      if (obs_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL %s cmd%0d cycle: got %0d want %0d", name, i, obs_q[i].cyc, exp_q[i].cyc);
      end
      if (obs_q[i].op != exp_q[i].op) begin
        errors++;
        $display("FAIL %s cmd%0d op: got %0d want %0d", name, i, obs_q[i].op, exp_q[i].op);
      end
      if (obs_q[i].val != exp_q[i].val) begin
        errors++;
        $display("FAIL %s cmd%0d in: got %0d want %0d", name, i, obs_q[i].val, exp_q[i].val);
      end
    end
    checks += 2;
    if (err !== m_err) begin
      errors++; $display("FAIL %s err: got %b want %b", name, err, m_err);
    end
    if (char_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready: got %b want 1", name, char_ready);
    end
    $display("stream %-12s chars=%0d cmds=%0d err=%b", name, stim.size(), obs_q.size(), err);
  endtask

  task automatic test_random(input int nchars);
    byte ops[8];
    int r;
    ops = '{"+", "-", "*", "/", "%", "i", "d", "p"};
    do_reset();
    for (int i = 0; i < nchars; i++) begin
      r = $urandom_range(0, 39);
      if (r < 20)      stim.push_back(byte'(48 + $urandom_range(0, 9)));
      else if (r < 28) stim.push_back(" ");
      else if (r < 30) stim.push_back(8'h0A);
      else if (r < 31) stim.push_back(8'h0D);
      else if (r < 39) stim.push_back(ops[$urandom_range(0, 7)]);
      else             stim.push_back("q");
    end
    test_stream("random", 1);
  endtask

  initial begin
    test_reset();
    test_reset_mid_stream();
    do_reset(); load_str("10 3 ");   test_stream("push_pair", 0);
    do_reset(); load_str("10 3+");   test_stream("op_pending", 0);
    do_reset(); load_str("7 i d p"); test_stream("unary_ops", 0);
    do_reset(); load_str("300 5 ");  test_stream("overflow", 0);
    do_reset(); load_str("x4 ");     test_stream("bad_char", 1);
    do_reset(); load_str("12*3-45/6%7+89i0\r1\n"); test_stream("back_to_back", 0);
    test_random(400);
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
